// File: rtl/gp_pkg.sv
// Shared definitions for the general-purpose writeback stage: load funct3
// encodings, writeback FSM states and the register index width.
package gp_pkg;

  localparam int REG_AW = 5;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [0:0] {
    WB_IDLE      = 1'b0,
    WB_LOAD_WAIT = 1'b1
  } wb_state_e;

endpackage

// File: rtl/gp_writeback_if.sv
// Issue channel from execute into writeback.
// valid/ready: an op transfers on a cycle where iss_valid && iss_ready;
// iss_ready is computed without looking at iss_valid.
interface gp_writeback_if #(
  parameter int XLEN = 32
);
  logic                      iss_valid;
  logic                      iss_ready;
  logic                      iss_is_load;
  logic [gp_pkg::REG_AW-1:0] iss_rd_addr;
  logic [2:0]                iss_funct3;
  logic [1:0]                iss_byte_off;
  logic [XLEN-1:0]           iss_alu_res;

  modport master (
    output iss_valid, iss_is_load, iss_rd_addr, iss_funct3, iss_byte_off, iss_alu_res,
    input  iss_ready
  );

  modport slave (
    input  iss_valid, iss_is_load, iss_rd_addr, iss_funct3, iss_byte_off, iss_alu_res,
    output iss_ready
  );
endinterface

// File: rtl/gp_load_ext.sv
// Load data extractor: selects the byte/half lane addressed by byte_off and
// sign- or zero-extends it according to funct3.
module gp_load_ext
  import gp_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      byte_off,
  input  logic [XLEN-1:0] word,
  output logic [XLEN-1:0] ext
);

  logic [1:0]  half_off;
  logic [7:0]  b_lane;
  logic [15:0] h_lane;

  always_comb begin
    // A halfword at offset 3 would straddle the word; fold it onto offset 2.
    half_off = (byte_off == 2'd3) ? 2'd2 : byte_off;
    b_lane   = 8'(word >> {byte_off, 3'b000});
    h_lane   = 16'(word >> {half_off, 3'b000});
    ext      = word;
    case (funct3)
      F3_LB:   ext = {{(XLEN-8){b_lane[7]}}, b_lane};
      F3_LH:   ext = {{(XLEN-16){h_lane[15]}}, h_lane};
      F3_LBU:  ext = {{(XLEN-8){1'b0}}, b_lane};
      F3_LHU:  ext = {{(XLEN-16){1'b0}}, h_lane};
      F3_LW:   ext = word;
      default: ext = word;
    endcase
  end

endmodule

// File: rtl/gp_writeback.sv
// Writeback stage: arbitrates load returns, a one-entry skid and ALU results
// onto the register file write port, and tracks pending loads for decode.
module gp_writeback
  import gp_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  gp_writeback_if.slave     iss,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              rd_w,
  output logic [REG_AW-1:0] rd_addr,
  output logic [XLEN-1:0]   rd,
  input  logic [REG_AW-1:0] q_rs1_addr,
  input  logic [REG_AW-1:0] q_rs2_addr,
  output logic              busy_rs1,
  output logic              busy_rs2,
  output logic              fwd_rs1_hit,
  output logic              fwd_rs2_hit,
  output wb_state_e         dbg_state
);

  wb_state_e         state_q, state_d;
  logic [REG_AW-1:0] pend_rd_q, pend_rd_d;
  logic [2:0]        pend_f3_q, pend_f3_d;
  logic [1:0]        pend_off_q, pend_off_d;
  logic              skid_valid_q, skid_valid_d;
  logic [REG_AW-1:0] skid_addr_q, skid_addr_d;
  logic [XLEN-1:0]   skid_data_q, skid_data_d;
  logic [NREG-1:0]   busy_q, busy_d;
  logic              rd_w_q, rd_w_d;
  logic [REG_AW-1:0] rd_addr_q, rd_addr_d;
  logic [XLEN-1:0]   rd_q, rd_d;

  logic            load_wait, load_ret, iss_ready_c, acc_alu, acc_load;
  logic [XLEN-1:0] ld_ext;

  gp_load_ext #(.XLEN(XLEN)) u_load_ext (
    .funct3   (pend_f3_q),
    .byte_off (pend_off_q),
    .word     (mem_rdata),
    .ext      (ld_ext)
  );

  always_comb begin
    load_wait = (state_q == WB_LOAD_WAIT);
    load_ret  = load_wait && mem_rvalid;
    // One outstanding load, and no younger write may overtake it to the same rd.
    iss_ready_c = !skid_valid_q &&
                  !(load_wait && (iss.iss_is_load || iss.iss_rd_addr == pend_rd_q));
    acc_alu  = iss.iss_valid && iss_ready_c && !iss.iss_is_load;
    acc_load = iss.iss_valid && iss_ready_c && iss.iss_is_load;

    state_d      = state_q;
    pend_rd_d    = pend_rd_q;
    pend_f3_d    = pend_f3_q;
    pend_off_d   = pend_off_q;
    skid_valid_d = skid_valid_q;
    skid_addr_d  = skid_addr_q;
    skid_data_d  = skid_data_q;
    busy_d       = busy_q;
    rd_w_d       = 1'b0;
    rd_addr_d    = rd_addr_q;
    rd_d         = rd_q;

    case (state_q)
      WB_IDLE:      if (acc_load) state_d = WB_LOAD_WAIT;
      WB_LOAD_WAIT: if (mem_rvalid) state_d = WB_IDLE;
      default:      state_d = WB_IDLE;
    endcase

    if (acc_load) begin
      pend_rd_d  = iss.iss_rd_addr;
      pend_f3_d  = iss.iss_funct3;
      pend_off_d = iss.iss_byte_off;
      if (iss.iss_rd_addr != '0) busy_d[iss.iss_rd_addr] = 1'b1;
    end

    // Port priority: load return, then skid, then this cycle's ALU op.
    if (load_ret) begin
      busy_d[pend_rd_q] = 1'b0;
      if (pend_rd_q != '0) begin
        rd_w_d    = 1'b1;
        rd_addr_d = pend_rd_q;
        rd_d      = ld_ext;
      end
      if (acc_alu && iss.iss_rd_addr != '0) begin
        skid_valid_d = 1'b1;
        skid_addr_d  = iss.iss_rd_addr;
        skid_data_d  = iss.iss_alu_res;
      end
    end else if (skid_valid_q) begin
      skid_valid_d = 1'b0;
      rd_w_d       = 1'b1;
      rd_addr_d    = skid_addr_q;
      rd_d         = skid_data_q;
    end else if (acc_alu && iss.iss_rd_addr != '0) begin
      rd_w_d    = 1'b1;
      rd_addr_d = iss.iss_rd_addr;
      rd_d      = iss.iss_alu_res;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= WB_IDLE;
      pend_rd_q    <= '0;
      pend_f3_q    <= '0;
      pend_off_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_addr_q  <= '0;
      skid_data_q  <= '0;
      busy_q       <= '0;
      rd_w_q       <= 1'b0;
      rd_addr_q    <= '0;
      rd_q         <= '0;
    end else begin
      state_q      <= state_d;
      pend_rd_q    <= pend_rd_d;
      pend_f3_q    <= pend_f3_d;
      pend_off_q   <= pend_off_d;
      skid_valid_q <= skid_valid_d;
      skid_addr_q  <= skid_addr_d;
      skid_data_q  <= skid_data_d;
      busy_q       <= busy_d;
      rd_w_q       <= rd_w_d;
      rd_addr_q    <= rd_addr_d;
      rd_q         <= rd_d;
    end
  end

  assign iss.iss_ready = iss_ready_c;
  assign rd_w          = rd_w_q;
  assign rd_addr       = rd_addr_q;
  assign rd            = rd_q;
  assign dbg_state     = state_q;
  assign busy_rs1      = (q_rs1_addr != '0) && busy_q[q_rs1_addr];
  assign busy_rs2      = (q_rs2_addr != '0) && busy_q[q_rs2_addr];
  assign fwd_rs1_hit   = rd_w_q && (rd_addr_q == q_rs1_addr) && (q_rs1_addr != '0);
  assign fwd_rs2_hit   = rd_w_q && (rd_addr_q == q_rs2_addr) && (q_rs2_addr != '0);

endmodule

// File: tb/tb_gp_writeback.sv
// Bench for gp_writeback: directed scenarios plus a randomized run scored
// against a transaction-level model of the writeback rules.
module tb_gp_writeback;
  import gp_pkg::*;

  localparam int XLEN = 32;
  localparam int W    = 5 + 32 + 32;  // {addr, data, due_cycle}

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gp_writeback_if #(.XLEN(XLEN)) iss_if ();

  logic            mem_rvalid;
  logic [31:0]     mem_rdata;
  logic            rd_w;
  logic [4:0]      rd_addr;
  logic [31:0]     rd;
  logic [4:0]      q_rs1_addr, q_rs2_addr;
  logic            busy_rs1, busy_rs2, fwd_rs1_hit, fwd_rs2_hit;
  wb_state_e       dbg_state;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  gp_writeback #(.XLEN(XLEN), .NREG(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .iss         (iss_if.slave),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .rd_w        (rd_w),
    .rd_addr     (rd_addr),
    .rd          (rd),
    .q_rs1_addr  (q_rs1_addr),
    .q_rs2_addr  (q_rs2_addr),
    .busy_rs1    (busy_rs1),
    .busy_rs2    (busy_rs2),
    .fwd_rs1_hit (fwd_rs1_hit),
    .fwd_rs2_hit (fwd_rs2_hit),
    .dbg_state   (dbg_state)
  );

  // Reference load extension written as plain arithmetic on the lane value.
  function automatic logic [31:0] ref_ext(input logic [2:0] f3, input logic [1:0] off,
                                          input logic [31:0] w);
    longint v;
    int o;
    o = (f3[1:0] == 2'b01 && off == 2'd3) ? 2 : int'(off);
    case (f3)
      3'b000: begin v = (longint'(w) >> (8*o)) % 256;   if (v >= 128)   v = v - 256;   end
      3'b001: begin v = (longint'(w) >> (8*o)) % 65536; if (v >= 32768) v = v - 65536; end
      3'b100: v = (longint'(w) >> (8*o)) % 256;
      3'b101: v = (longint'(w) >> (8*o)) % 65536;
      default: v = longint'(w);
    endcase
    return v[31:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    iss_if.iss_valid    = 1'b0;
    iss_if.iss_is_load  = 1'b0;
    iss_if.iss_rd_addr  = '0;
    iss_if.iss_funct3   = '0;
    iss_if.iss_byte_off = '0;
    iss_if.iss_alu_res  = '0;
    mem_rvalid          = 1'b0;
    mem_rdata           = '0;
    q_rs1_addr          = '0;
    q_rs2_addr          = '0;
  endtask

  task automatic drive_op(input logic is_load, input logic [4:0] a, input logic [2:0] f3,
                          input logic [1:0] off, input logic [31:0] res);
    iss_if.iss_valid    = 1'b1;
    iss_if.iss_is_load  = is_load;
    iss_if.iss_rd_addr  = a;
    iss_if.iss_funct3   = f3;
    iss_if.iss_byte_off = off;
    iss_if.iss_alu_res  = res;
  endtask

  task automatic test_reset();
    drive_idle();
    q_rs1_addr = 5'd1;
    #2;
    checks++;
    if (rd_w !== 1'b0 || rd_addr !== 5'd0 || rd !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: got rd_w=%b rd_addr=%0d rd=%h want 0/0/0", rd_w, rd_addr, rd);
    end
    checks++;
    if (dbg_state !== WB_IDLE || busy_rs1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got state=%0d busy=%b want IDLE/0", dbg_state, busy_rs1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_alu();
    drive_op(1'b0, 5'd5, 3'd0, 2'd0, 32'h1234_5678);
    #1;
    checks++;
    if (iss_if.iss_ready !== 1'b1) begin
      errors++; $display("FAIL alu_ready: got %b want 1", iss_if.iss_ready);
    end
    tick();
    drive_idle();
    q_rs1_addr = 5'd5;
    #1;
    checks++;
    if (rd_w !== 1'b1 || rd_addr !== 5'd5 || rd !== 32'h1234_5678 || fwd_rs1_hit !== 1'b1) begin
      errors++;
      $display("FAIL alu_write: got w=%b a=%0d d=%h fwd=%b want 1/5/12345678/1",
               rd_w, rd_addr, rd, fwd_rs1_hit);
    end
    tick();
    checks++;
    if (rd_w !== 1'b0) begin
      errors++; $display("FAIL alu_pulse: got rd_w=%b want 0", rd_w);
    end
  endtask

  task automatic test_load(input logic [2:0] f3, input logic [31:0] exp_val);
    drive_op(1'b1, 5'd7, f3, 2'd2, 32'hDEAD_BEEF);
    tick();
    drive_idle();
    q_rs1_addr = 5'd7;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0080_0000;
      end
      #1;
      checks++;
      if (busy_rs1 !== 1'b1 || dbg_state !== WB_LOAD_WAIT) begin
        errors++;
        $display("FAIL load_busy f3=%0d cyc=%0d: got busy=%b state=%0d want 1/LOAD_WAIT",
                 f3, i, busy_rs1, dbg_state);
      end
      tick();
    end
    drive_idle();
    q_rs1_addr = 5'd7;
    #1;
    checks++;
    if (rd_w !== 1'b1 || rd_addr !== 5'd7 || rd !== exp_val || busy_rs1 !== 1'b0 ||
        fwd_rs1_hit !== 1'b1) begin
      errors++;
      $display("FAIL load_write f3=%0d: got w=%b a=%0d d=%h busy=%b fwd=%b want 1/7/%h/0/1",
               f3, rd_w, rd_addr, rd, busy_rs1, fwd_rs1_hit, exp_val);
    end
    tick();
  endtask

  task automatic test_collision();
    drive_op(1'b1, 5'd3, F3_LW, 2'd0, 32'd0);
    tick();
    drive_idle();
    tick();
    drive_op(1'b0, 5'd4, 3'd0, 2'd0, 32'h0000_00AA);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0000_0011;
    #1;
    checks++;
    if (iss_if.iss_ready !== 1'b1) begin
      errors++; $display("FAIL coll_accept: got ready=%b want 1", iss_if.iss_ready);
    end
    tick();
    drive_idle();
    iss_if.iss_rd_addr = 5'd4;
    #1;
    checks++;
    if (rd_w !== 1'b1 || rd_addr !== 5'd3 || rd !== 32'h11) begin
      errors++;
      $display("FAIL coll_load_first: got w=%b a=%0d d=%h want 1/3/11", rd_w, rd_addr, rd);
    end
    checks++;
    if (iss_if.iss_ready !== 1'b0) begin
      errors++; $display("FAIL coll_skid_ready: got ready=%b want 0", iss_if.iss_ready);
    end
    tick();
    checks++;
    if (rd_w !== 1'b1 || rd_addr !== 5'd4 || rd !== 32'hAA || iss_if.iss_ready !== 1'b1) begin
      errors++;
      $display("FAIL coll_skid_write: got w=%b a=%0d d=%h ready=%b want 1/4/aa/1",
               rd_w, rd_addr, rd, iss_if.iss_ready);
    end
    drive_idle();
    tick();
  endtask

  task automatic test_hazard();
    drive_op(1'b1, 5'd9, F3_LW, 2'd0, 32'd0);
    tick();
    drive_op(1'b0, 5'd9, 3'd0, 2'd0, 32'h0000_0033);
    #1;
    checks++;
    if (iss_if.iss_ready !== 1'b0) begin
      errors++; $display("FAIL haz_waw: got ready=%b want 0", iss_if.iss_ready);
    end
    tick();
    drive_op(1'b1, 5'd12, F3_LW, 2'd0, 32'd0);
    #1;
    checks++;
    if (iss_if.iss_ready !== 1'b0) begin
      errors++; $display("FAIL haz_second_load: got ready=%b want 0", iss_if.iss_ready);
    end
    tick();
    drive_op(1'b0, 5'd10, 3'd0, 2'd0, 32'h0000_1010);
    #1;
    checks++;
    if (iss_if.iss_ready !== 1'b1) begin
      errors++; $display("FAIL haz_other_rd: got ready=%b want 1", iss_if.iss_ready);
    end
    tick();
    checks++;
    if (rd_w !== 1'b1 || rd_addr !== 5'd10 || rd !== 32'h1010) begin
      errors++;
      $display("FAIL haz_other_write: got w=%b a=%0d d=%h want 1/10/1010", rd_w, rd_addr, rd);
    end
    drive_op(1'b0, 5'd9, 3'd0, 2'd0, 32'h0000_0033);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hCAFE_F00D;
    #1;
    checks++;
    if (iss_if.iss_ready !== 1'b0) begin
      errors++; $display("FAIL haz_waw_return: got ready=%b want 0", iss_if.iss_ready);
    end
    tick();
    mem_rvalid = 1'b0;
    #1;
    checks++;
    if (rd_w !== 1'b1 || rd_addr !== 5'd9 || rd !== 32'hCAFE_F00D || iss_if.iss_ready !== 1'b1) begin
      errors++;
      $display("FAIL haz_load_write: got w=%b a=%0d d=%h ready=%b want 1/9/cafef00d/1",
               rd_w, rd_addr, rd, iss_if.iss_ready);
    end
    tick();
    drive_idle();
    checks++;
    if (rd_w !== 1'b1 || rd_addr !== 5'd9 || rd !== 32'h33) begin
      errors++;
      $display("FAIL haz_waw_write: got w=%b a=%0d d=%h want 1/9/33", rd_w, rd_addr, rd);
    end
    tick();
  endtask

  task automatic test_x0();
    drive_op(1'b0, 5'd0, 3'd0, 2'd0, 32'h0000_0099);
    #1;
    checks++;
    if (iss_if.iss_ready !== 1'b1) begin
      errors++; $display("FAIL x0_alu_ready: got %b want 1", iss_if.iss_ready);
    end
    tick();
    drive_op(1'b1, 5'd0, F3_LW, 2'd0, 32'd0);
    #1;
    checks++;
    if (rd_w !== 1'b0 || iss_if.iss_ready !== 1'b1) begin
      errors++;
      $display("FAIL x0_alu_drop: got rd_w=%b ready=%b want 0/1", rd_w, iss_if.iss_ready);
    end
    tick();
    drive_idle();
    #1;
    checks++;
    if (busy_rs1 !== 1'b0 || dbg_state !== WB_LOAD_WAIT || rd_w !== 1'b0) begin
      errors++;
      $display("FAIL x0_load_wait: got busy=%b state=%0d rd_w=%b want 0/LOAD_WAIT/0",
               busy_rs1, dbg_state, rd_w);
    end
    tick();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1234_0000;
    tick();
    mem_rvalid = 1'b0;
    #1;
    checks++;
    if (rd_w !== 1'b0 || dbg_state !== WB_IDLE) begin
      errors++;
      $display("FAIL x0_load_drop: got rd_w=%b state=%0d want 0/IDLE", rd_w, dbg_state);
    end
    tick();
  endtask

  task automatic test_random();
    int cyc;
    logic pend_v, skid_full, skid_next, ld_ret, acc, wr_now, ready_exp;
    logic [4:0] pend_rd;
    logic [2:0] pend_f3;
    logic [1:0] pend_off;
    logic [W-1:0] e;
    logic v_valid, v_load, v_mrv;
    logic [4:0] v_rd, v_rs1, v_rs2;
    logic [2:0] v_f3;
    logic [1:0] v_off;
    logic [31:0] v_res, v_mdata;
    cyc = 0; pend_v = 1'b0; skid_full = 1'b0;
    pend_rd = '0; pend_f3 = '0; pend_off = '0;
    exp_q.delete();
    for (int k = 0; k < 320; k++) begin
      @(posedge clk);
      cyc++;
      #1;
      if (k < 300) begin
        v_valid = 1'($urandom_range(0, 1));
        v_load  = ($urandom_range(0, 3) == 0);
        v_mrv   = ($urandom_range(0, 2) == 0);
      end else begin
        v_valid = 1'b0; v_load = 1'b0; v_mrv = 1'b1;
      end
      v_rd    = 5'($urandom_range(0, 3));
      v_rs1   = 5'($urandom_range(0, 3));
      v_rs2   = 5'($urandom_range(0, 3));
      v_f3    = 3'($urandom_range(0, 7));
      v_off   = 2'($urandom_range(0, 3));
      v_res   = $urandom;
      v_mdata = $urandom;
      iss_if.iss_valid = v_valid; iss_if.iss_is_load = v_load; iss_if.iss_rd_addr = v_rd;
      iss_if.iss_funct3 = v_f3; iss_if.iss_byte_off = v_off; iss_if.iss_alu_res = v_res;
      mem_rvalid = v_mrv; mem_rdata = v_mdata; q_rs1_addr = v_rs1; q_rs2_addr = v_rs2;
      #1;
      wr_now = (exp_q.size() > 0) && (exp_q[0][31:0] == 32'(cyc));
      e = wr_now ? exp_q.pop_front() : '0;
      checks++;
      if (rd_w !== wr_now || (wr_now && (rd_addr !== e[68:64] || rd !== e[63:32]))) begin
        errors++;
        $display("FAIL rand_write cyc=%0d: got w=%b a=%0d d=%h want w=%b a=%0d d=%h",
                 cyc, rd_w, rd_addr, rd, wr_now, e[68:64], e[63:32]);
      end
      checks++;
      if (fwd_rs1_hit !== (wr_now && e[68:64] == v_rs1 && v_rs1 != 0) ||
          fwd_rs2_hit !== (wr_now && e[68:64] == v_rs2 && v_rs2 != 0)) begin
        errors++;
        $display("FAIL rand_fwd cyc=%0d: got %b%b", cyc, fwd_rs1_hit, fwd_rs2_hit);
      end
      ready_exp = !skid_full && !(pend_v && (v_load || v_rd == pend_rd));
      checks++;
      if (iss_if.iss_ready !== ready_exp) begin
        errors++;
        $display("FAIL rand_ready cyc=%0d: got %b want %b", cyc, iss_if.iss_ready, ready_exp);
      end
      checks++;
      if (busy_rs1 !== (pend_v && pend_rd != 0 && v_rs1 == pend_rd) ||
          busy_rs2 !== (pend_v && pend_rd != 0 && v_rs2 == pend_rd) ||
          dbg_state !== (pend_v ? WB_LOAD_WAIT : WB_IDLE)) begin
        errors++;
        $display("FAIL rand_busy cyc=%0d: got b1=%b b2=%b state=%0d pend=%b rd=%0d",
                 cyc, busy_rs1, busy_rs2, dbg_state, pend_v, pend_rd);
      end
      ld_ret    = pend_v && v_mrv;
      acc       = v_valid && ready_exp;
      skid_next = 1'b0;
      if (ld_ret) begin
        if (pend_rd != 0) exp_q.push_back({pend_rd, ref_ext(pend_f3, pend_off, v_mdata), 32'(cyc + 1)});
        pend_v = 1'b0;
      end
      if (acc && !v_load && v_rd != 0) begin
        exp_q.push_back({v_rd, v_res, 32'(ld_ret ? cyc + 2 : cyc + 1)});
        skid_next = ld_ret;
      end
      if (acc && v_load) begin
        pend_v = 1'b1; pend_rd = v_rd; pend_f3 = v_f3; pend_off = v_off;
      end
      skid_full = skid_next;
    end
    drive_idle();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rand_drain: got %0d writes outstanding want 0", exp_q.size());
    end
    tick();
  endtask

  task automatic test_reset_mid_load();
    drive_op(1'b1, 5'd6, F3_LW, 2'd0, 32'd0);
    tick();
    drive_op(1'b0, 5'd10, 3'd0, 2'd0, 32'h0000_0055);
    tick();
    drive_idle();
    q_rs1_addr = 5'd6;
    #1;
    checks++;
    if (rd_w !== 1'b1 || busy_rs1 !== 1'b1) begin
      errors++; $display("FAIL rst_pre: got rd_w=%b busy=%b want 1/1", rd_w, busy_rs1);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (rd_w !== 1'b0 || rd_addr !== 5'd0 || rd !== 32'd0 || busy_rs1 !== 1'b0 ||
        dbg_state !== WB_IDLE) begin
      errors++;
      $display("FAIL rst_async: got w=%b a=%0d d=%h busy=%b state=%0d want all 0",
               rd_w, rd_addr, rd, busy_rs1, dbg_state);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEAD_0000;
    tick();
    mem_rvalid = 1'b0;
    iss_if.iss_is_load = 1'b1;
    iss_if.iss_rd_addr = 5'd6;
    #1;
    checks++;
    if (rd_w !== 1'b0 || dbg_state !== WB_IDLE || iss_if.iss_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_ignore_rvalid: got w=%b state=%0d ready=%b want 0/IDLE/1",
               rd_w, dbg_state, iss_if.iss_ready);
    end
    drive_idle();
    tick();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load(F3_LB, 32'hFFFF_FF80);
    test_load(F3_LBU, 32'h0000_0080);
    test_collision();
    test_hazard();
    test_x0();
    test_random();
    test_reset_mid_load();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
